// File: rtl/ll_pkg.sv
// Shared linked-list package: operation and response encodings, datapath width
// and the default manager-timeout used by the response generator.
package ll_pkg;

  localparam int DATAMEM_WIDTH      = 32;
  localparam int RESP_STATUS_W      = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_INSERT = 3'd1,
    OP_DELETE = 3'd2,
    OP_SEARCH = 3'd3,
    OP_READ   = 3'd4,
    OP_UPDATE = 3'd5
  } t_mainop_types;

  typedef enum logic [RESP_STATUS_W-1:0] {
    RESP_OK         = 3'd0,
    RESP_NO_OP      = 3'd1,
    RESP_DECODE_ERR = 3'd2,
    RESP_MNGR_ERR   = 3'd3,
    RESP_TIMEOUT    = 3'd4
  } t_resp_status;

  // OK and NO_OP are the only statuses that do not count as errors.
  function automatic logic is_err_status(input t_resp_status s);
    return (s != RESP_OK) && (s != RESP_NO_OP);
  endfunction

endpackage

// File: rtl/ll_resp_watchdog.sv
// Loadable up-counter that flags expiry at TIMEOUT_CYCLES-1 and holds there
// until cleared, so a late enable can never wrap it back to a live value.
module ll_resp_watchdog
  import ll_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == EXPIRE_AT);

endmodule

// File: rtl/ll_resp_gen_unit.sv
// Response end of the linked-list request path: turns decoder and manager
// events into one handshaked response each, with watchdog and statistics.
module ll_resp_gen_unit
  import ll_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMO_CNT_WIDTH  = $clog2(TIMEOUT_CYCLES) + 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     resp_no_op,
  input  logic                     resp_gen_decode_err,
  input  logic                     resp_gen_decode_err_type,
  input  logic                     req_taken,
  input  logic                     mngr_op_done,
  input  logic                     mngr_op_err,
  input  logic                     mngr_rd_data_vld,
  input  logic [DATAMEM_WIDTH-1:0] mngr_rd_data,
  output logic                     resp_vld,
  input  logic                     resp_rdy,
  output logic [RESP_STATUS_W-1:0] resp_status,
  output logic [DATAMEM_WIDTH-1:0] resp_data,
  output logic                     resp_gen_cmpltd,
  output logic                     resp_gen_idle,
  output logic [CNT_WIDTH-1:0]     rsp_cnt,
  output logic [CNT_WIDTH-1:0]     err_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MNGR = 2'd1,
    SEND_RESP = 2'd2,
    CMPLT     = 2'd3
  } t_resp_fsm_st;

  t_resp_fsm_st             r_state;
  t_resp_status             r_status;
  logic [DATAMEM_WIDTH-1:0] r_data;
  logic                     r_vld;
  logic                     r_cmpltd;
  logic                     r_idle;
  logic [CNT_WIDTH-1:0]     r_rsp_cnt;
  logic [CNT_WIDTH-1:0]     r_err_cnt;

  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expired;
  logic w_handshake;

  // Watchdog restarts only when a request is actually forwarded to the manager.
  assign w_wd_clr    = (r_state == IDLE) && req_taken &&
                       !resp_gen_decode_err && !resp_no_op;
  assign w_wd_en     = (r_state == WAIT_MNGR);
  assign w_handshake = (r_state == SEND_RESP) && resp_rdy;

  ll_resp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (TMO_CNT_WIDTH)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .i_load    (1'b0),
    .i_load_val('0),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_status  <= RESP_OK;
      r_data    <= '0;
      r_vld     <= 1'b0;
      r_cmpltd  <= 1'b0;
      r_idle    <= 1'b1;
      r_rsp_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (resp_gen_decode_err) begin
            r_status <= RESP_DECODE_ERR;
            r_data   <= {{(DATAMEM_WIDTH-1){1'b0}}, resp_gen_decode_err_type};
            r_vld    <= 1'b1;
            r_idle   <= 1'b0;
            r_state  <= SEND_RESP;
          end else if (resp_no_op) begin
            r_status <= RESP_NO_OP;
            r_data   <= '0;
            r_vld    <= 1'b1;
            r_idle   <= 1'b0;
            r_state  <= SEND_RESP;
          end else if (req_taken) begin
            r_idle   <= 1'b0;
            r_state  <= WAIT_MNGR;
          end
        end

        WAIT_MNGR: begin
          // A done on the expiry cycle still reports the manager's result.
          if (mngr_op_done) begin
            r_status <= mngr_op_err ? RESP_MNGR_ERR : RESP_OK;
            r_data   <= mngr_rd_data_vld ? mngr_rd_data : '0;
            r_vld    <= 1'b1;
            r_state  <= SEND_RESP;
          end else if (w_wd_expired) begin
            r_status <= RESP_TIMEOUT;
            r_data   <= '0;
            r_vld    <= 1'b1;
            r_state  <= SEND_RESP;
          end
        end

        SEND_RESP: begin
          if (w_handshake) begin
            r_vld     <= 1'b0;
            r_cmpltd  <= 1'b1;
            r_rsp_cnt <= r_rsp_cnt + CNT_WIDTH'(1);
            if (is_err_status(r_status) && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
            r_state   <= CMPLT;
          end
        end

        default: begin
          r_cmpltd <= 1'b0;
          r_idle   <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign resp_vld        = r_vld;
  assign resp_status     = r_status;
  assign resp_data       = r_data;
  assign resp_gen_cmpltd = r_cmpltd;
  assign resp_gen_idle   = r_idle;
  assign rsp_cnt         = r_rsp_cnt;
  assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_ll_resp_gen_unit.sv
// Directed bench for ll_resp_gen_unit: table of single-response vectors plus
// hand-written timeout, collision, reset and counter-wrap sequences.
module tb_ll_resp_gen_unit;
  import ll_pkg::*;

  localparam int TMO   = 8;
  localparam int CNT_W = 4;
  localparam int DW    = DATAMEM_WIDTH;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     resp_no_op;
  logic                     resp_gen_decode_err;
  logic                     resp_gen_decode_err_type;
  logic                     req_taken;
  logic                     mngr_op_done;
  logic                     mngr_op_err;
  logic                     mngr_rd_data_vld;
  logic [DW-1:0]            mngr_rd_data;
  logic                     resp_vld;
  logic                     resp_rdy;
  logic [RESP_STATUS_W-1:0] resp_status;
  logic [DW-1:0]            resp_data;
  logic                     resp_gen_cmpltd;
  logic                     resp_gen_idle;
  logic [CNT_W-1:0]         rsp_cnt;
  logic [CNT_W-1:0]         err_cnt;

  ll_resp_gen_unit #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (CNT_W)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .resp_no_op              (resp_no_op),
    .resp_gen_decode_err     (resp_gen_decode_err),
    .resp_gen_decode_err_type(resp_gen_decode_err_type),
    .req_taken               (req_taken),
    .mngr_op_done            (mngr_op_done),
    .mngr_op_err             (mngr_op_err),
    .mngr_rd_data_vld        (mngr_rd_data_vld),
    .mngr_rd_data            (mngr_rd_data),
    .resp_vld                (resp_vld),
    .resp_rdy                (resp_rdy),
    .resp_status             (resp_status),
    .resp_data               (resp_data),
    .resp_gen_cmpltd         (resp_gen_cmpltd),
    .resp_gen_idle           (resp_gen_idle),
    .rsp_cnt                 (rsp_cnt),
    .err_cnt                 (err_cnt)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_NOOP, EV_DECERR, EV_MNGR, EV_DECERR_NOOP} t_ev;

  typedef struct {
    t_ev           kind;
    logic          err_type;
    logic          m_err;
    logic          m_vld;
    logic [DW-1:0] m_data;
    int            rdy_delay;
    logic          rdy_early;
    logic [2:0]    exp_status;
    logic [DW-1:0] exp_data;
  } t_vec;

  t_vec vecs[7];

  int             n_checks = 0;
  int             n_errors = 0;
  logic [CNT_W-1:0] exp_rsp = '0;
  logic [CNT_W-1:0] exp_err = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the statistics counters: rsp wraps, err saturates.
  task automatic model_deliver(input logic [2:0] st);
    exp_rsp = exp_rsp + CNT_W'(1);
    if (st != 3'd0 && st != 3'd1 && exp_err != '1) exp_err = exp_err + CNT_W'(1);
  endtask

  // Response is already valid on entry; apply backpressure, then handshake.
  task automatic deliver(input logic [2:0] st, input logic [DW-1:0] d, input int delay);
    for (int i = 0; i < delay; i++) begin
      resp_rdy = 1'b0;
      tick();
      check("held_vld", resp_vld, 1'b1);
      check("held_status", resp_status, st);
      check("held_data", resp_data, d);
    end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    model_deliver(st);
    check("cmplt_vld_low", resp_vld, 1'b0);
    check("cmpltd_pulse", resp_gen_cmpltd, 1'b1);
    check("cmplt_not_idle", resp_gen_idle, 1'b0);
    tick();
    check("cmpltd_one_cycle", resp_gen_cmpltd, 1'b0);
    check("back_idle", resp_gen_idle, 1'b1);
    check("rsp_cnt", rsp_cnt, exp_rsp);
    check("err_cnt", err_cnt, exp_err);
  endtask

  task automatic pulse_decerr(input logic t);
    resp_gen_decode_err      = 1'b1;
    resp_gen_decode_err_type = t;
    tick();
    resp_gen_decode_err      = 1'b0;
    resp_gen_decode_err_type = 1'b0;
  endtask

  task automatic run_vector(input t_vec v);
    resp_rdy = v.rdy_early;
    case (v.kind)
      EV_NOOP: begin
        resp_no_op = 1'b1;
        tick();
        resp_no_op = 1'b0;
      end
      EV_DECERR: pulse_decerr(v.err_type);
      EV_DECERR_NOOP: begin
        resp_no_op = 1'b1;
        pulse_decerr(v.err_type);
        resp_no_op = 1'b0;
      end
      default: begin
        req_taken = 1'b1;
        tick();
        req_taken = 1'b0;
        check("wait_not_idle", resp_gen_idle, 1'b0);
        for (int i = 0; i < 4; i++) begin
          resp_no_op = (i == 1);  // decoder pulse during WAIT_MNGR is ignored
          tick();
          check("wait_no_vld", resp_vld, 1'b0);
        end
        resp_no_op       = 1'b0;
        mngr_op_done     = 1'b1;
        mngr_op_err      = v.m_err;
        mngr_rd_data_vld = v.m_vld;
        mngr_rd_data     = v.m_data;
        tick();
        mngr_op_done     = 1'b0;
        mngr_op_err      = 1'b0;
        mngr_rd_data_vld = 1'b0;
        mngr_rd_data     = '0;
      end
    endcase
    check("vld_latency", resp_vld, 1'b1);
    check("status", resp_status, v.exp_status);
    check("data", resp_data, v.exp_data);
    deliver(v.exp_status, v.exp_data, v.rdy_delay);
  endtask

  // req_taken then silence; optionally done lands exactly on the expiry cycle.
  task automatic run_timeout(input logic done_on_expiry, input logic [2:0] st, input logic [DW-1:0] d);
    req_taken = 1'b1;
    tick();
    req_taken = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("tmo_pending", resp_vld, 1'b0);
    end
    mngr_op_done     = done_on_expiry;
    mngr_rd_data_vld = done_on_expiry;
    mngr_rd_data     = d;
    tick();
    mngr_op_done     = 1'b0;
    mngr_rd_data_vld = 1'b0;
    mngr_rd_data     = '0;
    check("tmo_vld", resp_vld, 1'b1);
    check("tmo_status", resp_status, st);
    check("tmo_data", resp_data, done_on_expiry ? d : '0);
    deliver(st, done_on_expiry ? d : '0, 1);
  endtask

  initial begin
    vecs[0] = '{kind: EV_NOOP, err_type: 1'b0, m_err: 1'b0, m_vld: 1'b0, m_data: '0,
                rdy_delay: 0, rdy_early: 1'b1, exp_status: 3'd1, exp_data: '0};
    vecs[1] = '{kind: EV_MNGR, err_type: 1'b0, m_err: 1'b0, m_vld: 1'b1, m_data: 32'hA5,
                rdy_delay: 4, rdy_early: 1'b0, exp_status: 3'd0, exp_data: 32'hA5};
    vecs[2] = '{kind: EV_MNGR, err_type: 1'b0, m_err: 1'b1, m_vld: 1'b0, m_data: 32'hDEADBEEF,
                rdy_delay: 1, rdy_early: 1'b0, exp_status: 3'd3, exp_data: '0};
    vecs[3] = '{kind: EV_DECERR_NOOP, err_type: 1'b1, m_err: 1'b0, m_vld: 1'b0, m_data: '0,
                rdy_delay: 2, rdy_early: 1'b0, exp_status: 3'd2, exp_data: 32'd1};
    vecs[4] = '{kind: EV_DECERR, err_type: 1'b0, m_err: 1'b0, m_vld: 1'b0, m_data: '0,
                rdy_delay: 0, rdy_early: 1'b0, exp_status: 3'd2, exp_data: '0};
    vecs[5] = '{kind: EV_MNGR, err_type: 1'b0, m_err: 1'b0, m_vld: 1'b0, m_data: 32'h1234,
                rdy_delay: 0, rdy_early: 1'b0, exp_status: 3'd0, exp_data: '0};
    vecs[6] = '{kind: EV_MNGR, err_type: 1'b0, m_err: 1'b1, m_vld: 1'b1, m_data: 32'h5A5A,
                rdy_delay: 3, rdy_early: 1'b1, exp_status: 3'd3, exp_data: 32'h5A5A};

    reset = 1'b1;
    resp_no_op = 1'b0; resp_gen_decode_err = 1'b0; resp_gen_decode_err_type = 1'b0;
    req_taken = 1'b0; mngr_op_done = 1'b0; mngr_op_err = 1'b0;
    mngr_rd_data_vld = 1'b0; mngr_rd_data = '0; resp_rdy = 1'b0;
    repeat (3) tick();
    check("rst_vld", resp_vld, 1'b0);
    check("rst_idle", resp_gen_idle, 1'b1);
    check("rst_cmpltd", resp_gen_cmpltd, 1'b0);
    check("rst_status", resp_status, 3'd0);
    check("rst_data", resp_data, '0);
    check("rst_rsp_cnt", rsp_cnt, '0);
    check("rst_err_cnt", err_cnt, '0);
    reset = 1'b0;
    repeat (6) tick();

    for (int i = 0; i < 7; i++) run_vector(vecs[i]);

    run_timeout(1'b0, 3'd4, '0);
    run_timeout(1'b1, 3'd0, 32'hC0FFEE);

    // mngr_op_done in IDLE must not create a response.
    mngr_op_done = 1'b1; mngr_rd_data_vld = 1'b1; mngr_rd_data = 32'h77;
    tick();
    mngr_op_done = 1'b0; mngr_rd_data_vld = 1'b0; mngr_rd_data = '0;
    for (int i = 0; i < 3; i++) begin
      check("idle_done_no_vld", resp_vld, 1'b0);
      check("idle_done_idle", resp_gen_idle, 1'b1);
      tick();
    end

    // Reset during SEND_RESP: asynchronous drop, counters cleared, no cmpltd.
    pulse_decerr(1'b1);
    check("pre_rst_vld", resp_vld, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_vld", resp_vld, 1'b0);
    check("async_rst_rsp_cnt", rsp_cnt, '0);
    check("async_rst_err_cnt", err_cnt, '0);
    exp_rsp = '0;
    exp_err = '0;
    tick();
    reset = 1'b0;
    resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_cmpltd", resp_gen_cmpltd, 1'b0);
      check("post_rst_idle", resp_gen_idle, 1'b1);
    end
    resp_rdy = 1'b0;

    // 2^CNT_W + 3 error responses: rsp_cnt wraps, err_cnt saturates.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      pulse_decerr(i[0]);
      check("wrap_vld", resp_vld, 1'b1);
      deliver(3'd2, {{(DW-1){1'b0}}, i[0]}, 0);
    end
    check("final_rsp_cnt_wrapped", rsp_cnt, 4'd3);
    check("final_err_cnt_sat", err_cnt, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog for the bench itself so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL bench_timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
